// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by a small byte FIFO; o_tx is registered and idles high.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 28,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;

    state_e          state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
`ifdef UART_TX_PARITY_EN
    logic            parity_q;
`endif

    logic fifo_empty, push, pop, baud_last;

    always_comb begin
        fifo_empty = (count_q == '0);
        o_ready    = (count_q != CntFull);
        push       = i_valid && o_ready;
        baud_last  = (baud_q == BaudLast);
        pop        = !fifo_empty && ((state_q == StIdle) || (state_q == StStop && baud_last));
        o_busy     = (state_q != StIdle) || !fifo_empty;
        o_tx       = tx_q;
        o_overflow = overflow_q;
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (i_valid && !o_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // tx_q is decoded from the pre-edge state, so the line lags the FSM by one clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q  <= mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^mem[rd_ptr_q];
`endif
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    tx_q <= 1'b0;
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    tx_q <= shift_q[0];
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    tx_q <= parity_q;
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q  <= mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^mem[rd_ptr_q];
`endif
                            state_q  <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued, a serial monitor decodes o_tx and compares.
// Directed timing checks cover start latency, frame length, back-to-back frames, overflow and reset.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready, tx, busy, overflow;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    bit abort_frame = 1'b0;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_valid   (valid),
        .o_ready   (ready),
        .o_tx      (tx),
        .o_busy    (busy),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Serial monitor: samples mid-bit on negedges, pops the scoreboard per frame.
    initial begin
        forever begin
            logic [7:0] rx;
            logic       par;
            logic       stp;
            logic [7:0] e;
            par = 1'b0;
            @(negedge clk);
            if (tx === 1'b0 && !rst) begin
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    rx[i] = tx;
                    if (i < 7) repeat (CPB) @(negedge clk);
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                par = tx;
`endif
                repeat (CPB) @(negedge clk);
                stp = tx;
                if (abort_frame) begin
                    abort_frame = 1'b0;
                end else if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected no frame", rx);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", {24'd0, rx}, {24'd0, e});
                    check("stop_bit", {31'd0, stp}, 32'd1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", {31'd0, par}, {31'd0, ^e});
`endif
                end
            end
        end
    end

    // Waits for o_ready (bounded), then offers one byte for exactly one accepting edge.
    task automatic push1(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("push_ready_timeout", 32'd1, 32'd0);
        data  = b;
        valid = 1'b1;
        exp_q.push_back(b);
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    // Counts negedges with o_busy high; also returns o_tx at the first three of them.
    task automatic busy_len(output int n, output logic [2:0] tx_first);
        n = 0;
        tx_first = 3'b000;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (k < 3) tx_first[k] = tx;
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0] txf;
        logic [7:0] ov[6];
        logic [5:0] exp_acc;
        logic [7:0] sweep[10];

        ov      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_acc = 6'b011111;
        sweep   = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'h7E, 8'hFE, 8'h3C, 8'hC3, 8'hF0, 8'h0F};

        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte: start latency and frame length.
        push1(8'hA5);
        busy_len(n, txf);
        check("a5_start_latency", {29'd0, txf}, 32'b011);
        check("a5_busy_len", n, FRAME + 1);
        repeat (2 * CPB) @(negedge clk);

        // Two bytes on consecutive cycles must run with no idle gap.
        @(negedge clk);
        check("b2b_ready", {31'd0, ready}, 32'd1);
        data  = 8'h00;
        valid = 1'b1;
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1 data = 8'hFF;
        exp_q.push_back(8'hFF);
        @(posedge clk);
        #1 valid = 1'b0;
        busy_len(n, txf);
        check("b2b_busy_len", n, 2 * FRAME);
        repeat (2 * CPB) @(negedge clk);

        // Six bytes offered on consecutive cycles: five fit, the sixth overflows.
        check("ovf_clear", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            data  = ov[i];
            valid = 1'b1;
            check($sformatf("ovf_ready_%0d", i), {31'd0, ready}, {31'd0, exp_acc[i]});
            if (exp_acc[i]) exp_q.push_back(ov[i]);
            @(posedge clk);
        end
        #1 valid = 1'b0;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (k == 0) check("ovf_set", {31'd0, overflow}, 32'd1);
            if (ready) break;
            n++;
        end
        check("ovf_ready_low_len", n, FRAME - 4);
        busy_len(n, txf);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        repeat (2 * CPB) @(negedge clk);

        // Reset during data bit 3 of 0x3C with two more bytes queued.
        push1(8'h3C);
        push1(8'h11);
        push1(8'h22);
        repeat (17) @(posedge clk);
        @(negedge clk);
        abort_frame = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        check("midrst_quiet", n, 0);

        // Parity vectors (0x07 odd weight, 0x03 even weight) and frame length.
        push1(8'h07);
        busy_len(n, txf);
        check("p07_busy_len", n, FRAME + 1);
        repeat (2 * CPB) @(negedge clk);
        push1(8'h03);
        busy_len(n, txf);
        check("p03_busy_len", n, FRAME + 1);
        repeat (2 * CPB) @(negedge clk);

        // Streamed sweep through the FIFO.
        for (int i = 0; i < 10; i++) push1(sweep[i]);
        busy_len(n, txf);
        repeat (4 * CPB) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, 8N1, LSB first, with a small FIFO on the byte side. It sits on the same GPIO UART link the controller-input receiver uses, driving the opposite direction: game logic pushes status bytes toward the external controller (e.g. rumble, ack, score). It runs on the baud-derived clock (3.226 MHz domain). Bit period is a whole number of clocks.

## Interface
- CLKS_PER_BIT, 28: clocks per serial bit; ≥ 2.
- FIFO_DEPTH, 4: byte FIFO entries; power of 2, ≥ 2.
- i_clk  input  1  sole clock; all logic on posedge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_data  input  8  byte to send; sampled on accept.
- i_valid  input  1  byte offered this cycle.
- o_ready  output  1  FIFO not full; accept = i_valid && o_ready at a posedge.
- o_tx  output  1  serial line, idle high; registered.
- o_busy  output  1  FIFO non-empty or frame in progress.
- o_overflow  output  1  sticky: i_valid seen while o_ready low; cleared only by reset.

## Operation
- The FIFO holds up to FIFO_DEPTH bytes. It has write and read pointers plus an occupancy count (log2(FIFO_DEPTH)+1 bits).
- o_ready = (count != FIFO_DEPTH). It is a registered-count decode with no combinational path from the pop. A full FIFO refuses a push even in the cycle it pops.
- Push and pop in the same cycle leave the count unchanged. A pop of an empty FIFO never happens.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: o_tx=1. If count≠0, pop into the 8-bit shift register and go to START.
- START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: o_tx=shift[0]; shift right every CLKS_PER_BIT cycles; after index 7 go to PARITY or STOP.
- STOP: o_tx=1 for CLKS_PER_BIT cycles.
  - In the last cycle, if count≠0, pop and go directly to START.
  - Otherwise go to IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1 and clears on every state change.
- o_busy = (state≠IDLE) || (count≠0).
- Reset values: o_tx=1, o_ready=1, o_busy=0, o_overflow=0. FSM goes to IDLE and the FIFO empties.

## Timing
- Accept at edge E into an empty FIFO with the FSM in IDLE:
  - count=1 after E.
  - Pop at E+1.
  - o_tx falls after E+2.
- Every bit, stop included, lasts exactly CLKS_PER_BIT cycles.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back bytes have zero idle gap: the next start bit follows the stop bit immediately.
- o_ready returns high one cycle after the pop that frees a slot.
- Reset asserted mid-frame: o_tx goes to 1 asynchronously and the FIFO contents are discarded. After release the FSM starts from IDLE; no partial frame resumes.
- Pushes during transmission never disturb the byte in the shift register.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is inserted between DATA and STOP.
  - o_tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 11 bits.
- Undefined: no PARITY state; DATA goes straight to STOP; 10-bit frame.

## Test plan
- CLKS_PER_BIT=4: push 0xA5 once.
  - o_tx low 2 cycles after accept.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop high 4 cycles.
  - o_busy falls after 40 cycles of frame.
- Push 0x00 then 0xFF on consecutive cycles: two frames with the second start bit adjacent to the first stop bit, no gap.
- FIFO_DEPTH=4: hold i_valid with 6 bytes while transmitting.
  - First pop frees a slot, so 5 accepted.
  - o_ready low while count=4.
  - o_overflow set and stays 1.
- Assert i_rst during DATA bit 3 of 0x3C:
  - o_tx=1 immediately.
  - o_ready=1, o_busy=0.
  - Queued bytes not sent after release.
- With UART_TX_PARITY_EN:
  - 0x07 → parity bit 1.
  - 0x03 → parity bit 0.
  - Frame 44 cycles at CLKS_PER_BIT=4.
- Loopback into the existing receiver at CLKS_PER_BIT=28: send 0x00..0xFF; every byte is received with valid asserted once.
